decode_stage: RTL and testbench

- Instruction-decode stage that produces the operand and control fields consumed by the program-counter block: op, os, ot, addr and imm_dpl.
- Takes the fetched instruction word and its pc and splits the fields.
- Reads the operands from an internal 32x32 register file, which has a writeback port.
- Detects load-use hazards and registers everything into the ID/EX pipeline register, with stall, flush and bubble handling.

---
 rtl/cpu_pkg.sv | 63 ++++++
 rtl/regfile.sv | 54 +++++
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and decode helpers
// used by the pc, decode, execute and hazard logic.
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam int OPW    = 6;

  typedef logic [OPW-1:0]    opcode_t;
  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam opcode_t OP_RTYPE = 6'd0;
  localparam opcode_t OP_LOAD  = 6'd16;
  localparam opcode_t OP_STORE = 6'd24;
  localparam opcode_t OP_BEQ   = 6'd32;
  localparam opcode_t OP_BNE   = 6'd33;
  localparam opcode_t OP_BLT   = 6'd34;
  localparam opcode_t OP_BLE   = 6'd35;
  localparam opcode_t OP_J     = 6'd40;
  localparam opcode_t OP_JAL   = 6'd41;
  localparam opcode_t OP_JR    = 6'd42;
  localparam opcode_t OP_NOP   = 6'd63;

  localparam reg_idx_t LINK_REG = 5'd31;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 0;

  // Register the instruction writes; 0 means no writeback.
  function automatic reg_idx_t dest_index(opcode_t op, reg_idx_t rt, reg_idx_t rd);
    reg_idx_t d;
    d = 5'd0;
    case (op) inside
      OP_RTYPE:        d = rd;
      [6'd1:OP_LOAD]:  d = rt;
      OP_JAL:          d = LINK_REG;
      OP_STORE, OP_BEQ, OP_BNE, OP_BLT, OP_BLE,
      OP_J, OP_JR, OP_NOP: d = 5'd0;
      default:         d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic reads_rt(opcode_t op);
    logic r;
    r = 1'b0;
    case (op)
      OP_RTYPE, OP_STORE, OP_BEQ, OP_BNE, OP_BLT, OP_BLE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two combinational read ports, one write port, r0 hard-wired
// to zero, with a same-cycle write-through path onto the read ports.
module regfile
  import cpu_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  output logic [DW-1:0]     rda,
  output logic [DW-1:0]     rdb,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DW-1:0]     wd
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (!rstd) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rda = '0;
    if (ra == 5'd0) begin
      rda = '0;
    end else if (we && (wa == ra)) begin
      rda = wd;
    end else begin
      rda = mem[ra];
    end
  end

  always_comb begin
    rdb = '0;
    if (rb == 5'd0) begin
      rdb = '0;
    end else if (we && (wa == rb)) begin
      rdb = wd;
    end else begin
      rdb = mem[rb];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: field split, operand read, load-use hazard detection and
// the ID/EX pipeline register with flush/stall/bubble handling.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                   clk,
  input  logic                   rstd,
  input  logic [DW-1:0]          ins,
  input  logic [DW-1:0]          pc_in,
  input  logic                   ins_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [REG_AW-1:0]      wb_addr,
  input  logic [DW-1:0]          wb_data,
  output logic [OPW-1:0]         op,
  output logic [DW-1:0]          os,
  output logic [DW-1:0]          ot,
  output logic [ADDR_MSB:ADDR_LSB] addr,
  output logic [DW-1:0]          imm_dpl,
  output logic [REG_AW-1:0]      dst,
  output logic [DW-1:0]          pc_out,
  output logic                   valid_out,
  output logic                   hazard_stall
);

  typedef struct packed {
    logic [OPW-1:0]           op;
    logic [DW-1:0]            os;
    logic [DW-1:0]            ot;
    logic [ADDR_MSB:ADDR_LSB] addr;
    logic [DW-1:0]            imm;
    logic [REG_AW-1:0]        dst;
    logic [DW-1:0]            pc;
    logic                     valid;
  } idex_t;

  idex_t             idex;
  idex_t             idex_next;
  idex_t             decoded;
  idex_t             bubble;
  opcode_t           dec_op;
  reg_idx_t          rs;
  reg_idx_t          rt;
  reg_idx_t          rd;
  logic [IMM_MSB:IMM_LSB] imm;
  logic [DW-1:0]     rs_val;
  logic [DW-1:0]     rt_val;

  assign dec_op = ins[OP_MSB:OP_LSB];
  assign rs     = ins[RS_MSB:RS_LSB];
  assign rt     = ins[RT_MSB:RT_LSB];
  assign rd     = ins[RD_MSB:RD_LSB];
  assign imm    = ins[IMM_MSB:IMM_LSB];

  regfile #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regfile (
    .clk  (clk),
    .rstd (rstd),
    .ra   (rs),
    .rb   (rt),
    .rda  (rs_val),
    .rdb  (rt_val),
    .we   (wb_en),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

  // A load in ID/EX whose result the decoding instruction needs cannot be bypassed yet.
  always_comb begin
    hazard_stall = 1'b0;
    if (idex.valid && (idex.op == OP_LOAD) && (idex.dst != 5'd0) && ins_valid) begin
      hazard_stall = (idex.dst == rs) || ((idex.dst == rt) && reads_rt(dec_op));
    end else begin
      hazard_stall = 1'b0;
    end
  end

  always_comb begin
    bubble    = '0;
    bubble.op = OP_NOP;

    decoded       = '0;
    decoded.op    = dec_op;
    decoded.os    = rs_val;
    decoded.ot    = rt_val;
    decoded.addr  = ins[ADDR_MSB:ADDR_LSB];
    decoded.imm   = {{(DW-16){imm[IMM_MSB]}}, imm};
    decoded.dst   = dest_index(dec_op, rt, rd);
    decoded.pc    = pc_in;
    decoded.valid = 1'b1;

    idex_next = idex;
    if (flush) begin
      idex_next = bubble;
    end else if (stall) begin
      idex_next = idex;
    end else if (hazard_stall) begin
      idex_next = bubble;
    end else if (!ins_valid) begin
      idex_next = bubble;
    end else begin
      idex_next = decoded;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      idex    <= '0;
      idex.op <= OP_NOP;
    end else begin
      idex <= idex_next;
    end
  end

  assign op        = idex.op;
  assign os        = idex.os;
  assign ot        = idex.ot;
  assign addr      = idex.addr;
  assign imm_dpl   = idex.imm;
  assign dst       = idex.dst;
  assign pc_out    = idex.pc;
  assign valid_out = idex.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstd;
  logic [31:0] ins;
  logic [31:0] pc_in;
  logic        ins_valid;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [5:0]  op;
  logic [31:0] os;
  logic [31:0] ot;
  logic [25:0] addr;
  logic [31:0] imm_dpl;
  logic [4:0]  dst;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        hazard_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk          (clk),
    .rstd         (rstd),
    .ins          (ins),
    .pc_in        (pc_in),
    .ins_valid    (ins_valid),
    .stall        (stall),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .op           (op),
    .os           (os),
    .ot           (ot),
    .addr         (addr),
    .imm_dpl      (imm_dpl),
    .dst          (dst),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .hazard_stall (hazard_stall)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstd = 1'b0; ins = 32'h0; pc_in = 32'h0; ins_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    step();
    step();
    chk("rst_op",    {26'd0, op}, 32'd63);
    chk("rst_os",    os, 32'h0);
    chk("rst_dst",   {27'd0, dst}, 32'd0);
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_hz",    {31'd0, hazard_stall}, 32'd0);
    rstd = 1'b1;

    // Write r3 and r4
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0005;
    step();
    wb_addr = 5'd4; wb_data = 32'hFFFF_FFFB;
    step();
    wb_en = 1'b0;

    // Branch: op 32, rs=3, rt=4, imm=0xFFF8
    ins = {6'd32, 5'd3, 5'd4, 16'hFFF8}; pc_in = 32'd10; ins_valid = 1'b1;
    step();
    chk("br_op",    {26'd0, op}, 32'd32);
    chk("br_os",    os, 32'h0000_0005);
    chk("br_ot",    ot, 32'hFFFF_FFFB);
    chk("br_imm",   imm_dpl, 32'hFFFF_FFF8);
    chk("br_pc",    pc_out, 32'd10);
    chk("br_valid", {31'd0, valid_out}, 32'd1);
    chk("br_dst",   {27'd0, dst}, 32'd0);
    chk("br_addr",  {6'd0, addr}, 32'h0064_FFF8);

    // Same-cycle bypass on rs
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
    ins = {6'd0, 5'd7, 5'd0, 5'd9, 11'd0}; pc_in = 32'd11;
    #1;
    chk("byp_hz", {31'd0, hazard_stall}, 32'd0);
    step();
    wb_en = 1'b0;
    chk("byp_os",  os, 32'h0000_1234);
    chk("byp_ot",  ot, 32'h0);
    chk("byp_dst", {27'd0, dst}, 32'd9);
    chk("byp_op",  {26'd0, op}, 32'd0);

    // Load rt=5 (rs=7 confirms r7 was stored)
    ins = {6'd16, 5'd7, 5'd5, 16'h0004}; pc_in = 32'd12;
    step();
    chk("ld_op",  {26'd0, op}, 32'd16);
    chk("ld_dst", {27'd0, dst}, 32'd5);
    chk("ld_os",  os, 32'h0000_1234);
    chk("ld_imm", imm_dpl, 32'h0000_0004);

    // Consumer reads r5 as rs
    ins = {6'd0, 5'd5, 5'd7, 5'd10, 11'd0}; pc_in = 32'd13;
    #1;
    chk("lu_hz1", {31'd0, hazard_stall}, 32'd1);
    step();
    chk("lu_bub_op",    {26'd0, op}, 32'd63);
    chk("lu_bub_valid", {31'd0, valid_out}, 32'd0);
    chk("lu_bub_dst",   {27'd0, dst}, 32'd0);
    chk("lu_hz0",       {31'd0, hazard_stall}, 32'd0);
    step();
    chk("lu_op",    {26'd0, op}, 32'd0);
    chk("lu_dst",   {27'd0, dst}, 32'd10);
    chk("lu_valid", {31'd0, valid_out}, 32'd1);
    chk("lu_pc",    pc_out, 32'd13);
    chk("lu_ot",    ot, 32'h0000_1234);

    // rt dependence only matters for instructions that read rt
    ins = {6'd16, 5'd2, 5'd6, 16'h0000}; pc_in = 32'd14;
    step();
    ins = {6'd1, 5'd2, 5'd6, 16'h0001};
    #1;
    chk("rt_alui_hz", {31'd0, hazard_stall}, 32'd0);
    ins = {6'd33, 5'd2, 5'd6, 16'h0001};
    #1;
    chk("rt_br_hz", {31'd0, hazard_stall}, 32'd1);
    step();

    // Flush wins over stall with a valid jal
    ins = {6'd41, 26'h000100}; pc_in = 32'd15; flush = 1'b1; stall = 1'b1;
    step();
    chk("fl_op",    {26'd0, op}, 32'd63);
    chk("fl_dst",   {27'd0, dst}, 32'd0);
    chk("fl_valid", {31'd0, valid_out}, 32'd0);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("jal_op",   {26'd0, op}, 32'd41);
    chk("jal_addr", {6'd0, addr}, 32'h0000_0100);
    chk("jal_dst",  {27'd0, dst}, 32'd31);
    chk("jal_valid", {31'd0, valid_out}, 32'd1);

    // Stall for three cycles with changing ins
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins = {6'd0, 5'd3, 5'd4, 5'd12 + 5'(i), 11'd0}; pc_in = 32'd16 + 32'(i);
      step();
      chk("stl_op",   {26'd0, op}, 32'd41);
      chk("stl_addr", {6'd0, addr}, 32'h0000_0100);
      chk("stl_dst",  {27'd0, dst}, 32'd31);
    end
    stall = 1'b0;
    ins = {6'd2, 5'd3, 5'd8, 16'h8000}; pc_in = 32'd20;
    step();
    chk("res_op",  {26'd0, op}, 32'd2);
    chk("res_dst", {27'd0, dst}, 32'd8);
    chk("res_os",  os, 32'h0000_0005);
    chk("res_imm", imm_dpl, 32'hFFFF_8000);
    chk("res_pc",  pc_out, 32'd20);

    // Writes to r0 are ignored, including the bypass path
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_DEAD;
    ins = {6'd0, 5'd0, 5'd0, 5'd1, 11'd0}; pc_in = 32'd21;
    step();
    chk("r0_byp_os", os, 32'h0);
    chk("r0_byp_ot", ot, 32'h0);
    wb_en = 1'b0;
    step();
    chk("r0_os", os, 32'h0);

    // Reset mid-stream
    ins = {6'd1, 5'd3, 5'd3, 16'h0000}; pc_in = 32'd22;
    rstd = 1'b0;
    step();
    chk("mrst_op",    {26'd0, op}, 32'd63);
    chk("mrst_valid", {31'd0, valid_out}, 32'd0);
    chk("mrst_dst",   {27'd0, dst}, 32'd0);
    chk("mrst_os",    os, 32'h0);
    chk("mrst_pc",    pc_out, 32'h0);
    rstd = 1'b1;
    #1;
    chk("mrst_hz", {31'd0, hazard_stall}, 32'd0);
    step();
    chk("mrst_r3",    os, 32'h0);
    chk("mrst_dst3",  {27'd0, dst}, 32'd3);
    chk("mrst_valid1", {31'd0, valid_out}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
